// File: rtl/subbytes_scheduler.sv
// Shares one byte-wide SubBytes S-box between the round datapath (16-byte state)
// and key expansion (4-byte SubWord): one job at a time, one byte per cycle.
module subbytes_scheduler #(
    parameter int SBOX_LAT = 1,
    parameter bit RR_ARB   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_req_valid,
    output logic         st_req_ready,
    input  logic [127:0] st_in,
    output logic         st_done,
    output logic [127:0] st_out,
    input  logic         ks_req_valid,
    output logic         ks_req_ready,
    input  logic [31:0]  ks_in,
    output logic         ks_done,
    output logic [31:0]  ks_out,
    output logic         busy,
    output logic [7:0]   sb_in,
    input  logic [7:0]   sb_out,
    output logic [1:0]   state_dbg
);
    // Handshake: a job transfers on a rising edge where valid && ready; ready is only
    // offered in IDLE, at most one side at a time, and a requester holds valid and data until then.
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

    state_t              state, state_nx;
    logic [127:0]        work;      // byte k at [127-8k -: 8]; key jobs use bytes 0..3
    logic [127:0]        work_cap;
    logic [4:0]          n_bytes, cnt;
    logic                own_ks, rr_ks, st_acc, ks_acc, accept;
    logic                iss_v, last_cap;
    logic [3:0]          iss_idx;
    logic [7:0]          next_byte;
    logic [SBOX_LAT-1:0] pv;
    logic [3:0]          pidx [SBOX_LAT];

    assign st_acc    = st_req_valid && st_req_ready;
    assign ks_acc    = ks_req_valid && ks_req_ready;
    assign accept    = st_acc || ks_acc;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ISSUE;
            ISSUE:   if (cnt == n_bytes) state_nx = DRAIN;
            DRAIN:   if (last_cap) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        st_req_ready = 1'b0;
        ks_req_ready = 1'b0;
        busy         = (state != IDLE);
        if (state == IDLE) begin
            if (st_req_valid && ks_req_valid) begin
                if (!RR_ARB || rr_ks) ks_req_ready = 1'b1;
                else                  st_req_ready = 1'b1;
            end else begin
                st_req_ready = st_req_valid;
                ks_req_ready = ks_req_valid;
            end
        end
    end

    // Byte selection for issue, and the buffer with the byte arriving this cycle merged in.
    always_comb begin
        next_byte = 8'h00;
        work_cap  = work;
        for (int k = 0; k < 16; k++) begin
            if (cnt[3:0] == 4'(k)) next_byte = work[127-8*k -: 8];
            if (pv[SBOX_LAT-1] && pidx[SBOX_LAT-1] == 4'(k)) work_cap[127-8*k -: 8] = sb_out;
        end
    end

    assign last_cap = (state == DRAIN) && pv[SBOX_LAT-1] &&
                      ({1'b0, pidx[SBOX_LAT-1]} == n_bytes - 5'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work    <= '0;
            n_bytes <= '0;
            cnt     <= '0;
            own_ks  <= 1'b0;
            rr_ks   <= 1'b1;
            iss_v   <= 1'b0;
            iss_idx <= '0;
            sb_in   <= '0;
            pv      <= '0;
            for (int i = 0; i < SBOX_LAT; i++) pidx[i] <= '0;
            st_out  <= '0;
            ks_out  <= '0;
            st_done <= 1'b0;
            ks_done <= 1'b0;
        end else begin
            st_done <= 1'b0;
            ks_done <= 1'b0;
            sb_in   <= 8'h00;
            iss_v   <= 1'b0;
            pv[0]   <= iss_v;
            pidx[0] <= iss_idx;
            for (int i = 1; i < SBOX_LAT; i++) begin
                pv[i]   <= pv[i-1];
                pidx[i] <= pidx[i-1];
            end
            if (pv[SBOX_LAT-1]) work <= work_cap;
            case (state)
                IDLE: if (accept) begin
                    work    <= ks_acc ? {ks_in, 96'h0} : st_in;
                    n_bytes <= ks_acc ? 5'd4 : 5'd16;
                    own_ks  <= ks_acc;
                    rr_ks   <= !ks_acc;
                    cnt     <= 5'd1;
                    sb_in   <= ks_acc ? ks_in[31:24] : st_in[127:120];
                    iss_v   <= 1'b1;
                    iss_idx <= 4'd0;
                end
                ISSUE: if (cnt != n_bytes) begin
                    sb_in   <= next_byte;
                    iss_v   <= 1'b1;
                    iss_idx <= cnt[3:0];
                    cnt     <= cnt + 5'd1;
                end
                DRAIN: if (last_cap) begin
                    if (own_ks) begin
                        ks_out  <= work_cap[127:96];
                        ks_done <= 1'b1;
                    end else begin
                        st_out  <= work_cap;
                        st_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_subbytes_scheduler.sv
// Bench for subbytes_scheduler in three configurations (registered/round-robin,
// registered/fixed priority, 3-stage/round-robin), each with its own S-box model and checker.
module tb_subbytes_scheduler;
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic [7:0] singles    [5] = '{8'h00, 8'h01, 8'h53, 8'hff, 8'h4f};
    logic [7:0] singles_sb [5] = '{8'h63, 8'h7c, 8'hed, 8'h16, 8'h84};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [2047:0] t;
        t = SBOX_TBL << (8 * int'(x));
        return t[2047:2040];
    endfunction

    function automatic logic [7:0] byte_of(input logic [127:0] v, input int k);
        logic [127:0] t;
        t = v << (8 * k);
        return t[127:120];
    endfunction

    function automatic logic [127:0] sub_all(input logic [127:0] v);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r = {r[119:0], sbox(byte_of(v, k))};
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input int c, input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %h expected %h", c, nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int LAT = (g == 2) ? 3 : 1;
        localparam bit RR  = (g != 1);

        logic         rst;
        logic         st_req_valid, st_req_ready, st_done;
        logic         ks_req_valid, ks_req_ready, ks_done, busy;
        logic [127:0] st_in, st_out;
        logic [31:0]  ks_in, ks_out;
        logic [7:0]   sb_in, sb_out;
        logic [1:0]   state_dbg;
        logic [7:0]   sb_pipe [LAT];
        logic         fin = 1'b0;
        int           cyc = 0;

        // Reference model: one outstanding job described by its accept cycle and byte count.
        bit           m_job, m_own_ks, m_ptr_ks;
        int           m_c0, m_n;
        logic [127:0] m_data, m_st;
        logic [31:0]  m_ks;
        logic [127:0] exp_q [$];

        subbytes_scheduler #(.SBOX_LAT(LAT), .RR_ARB(RR)) dut (
            .clk(clk), .rst(rst),
            .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_in(st_in),
            .st_done(st_done), .st_out(st_out),
            .ks_req_valid(ks_req_valid), .ks_req_ready(ks_req_ready), .ks_in(ks_in),
            .ks_done(ks_done), .ks_out(ks_out),
            .busy(busy), .sb_in(sb_in), .sb_out(sb_out), .state_dbg(state_dbg)
        );

        // Pipelined S-box with no reset, LAT cycles from sb_in to sb_out.
        always @(posedge clk) begin
            sb_pipe[0] <= sbox(sb_in);
            for (int i = 1; i < LAT; i++) sb_pipe[i] <= sb_pipe[i-1];
        end
        assign sb_out = sb_pipe[LAT-1];

        always @(negedge clk) begin : compare
            bit           e_done_st, e_done_ks, e_rdy_st, e_rdy_ks;
            logic [7:0]   e_sb;
            logic [127:0] r;
            int           k;
            cyc++;
            e_done_st = 0; e_done_ks = 0; e_rdy_st = 0; e_rdy_ks = 0; e_sb = 8'h00;
            r = '0;
            if (rst) begin
                m_job = 0; m_ptr_ks = 1; m_st = '0; m_ks = '0;
                exp_q.delete();
            end else if (m_job && cyc == m_c0 + m_n + LAT + 1) begin
                if (exp_q.size() > 0) r = exp_q.pop_front();
                if (m_own_ks) begin m_ks = r[127:96]; e_done_ks = 1; end
                else begin m_st = r; e_done_st = 1; end
                m_job = 0;
            end
            if (m_job) begin
                k = cyc - m_c0 - 1;
                if (k >= 0 && k < m_n) e_sb = byte_of(m_data, k);
            end else if (st_req_valid && ks_req_valid) begin
                if (RR && !m_ptr_ks) e_rdy_st = 1;
                else e_rdy_ks = 1;
            end else begin
                e_rdy_st = st_req_valid;
                e_rdy_ks = ks_req_valid;
            end
            chk(g, "st_req_ready", 128'(st_req_ready), 128'(e_rdy_st));
            chk(g, "ks_req_ready", 128'(ks_req_ready), 128'(e_rdy_ks));
            chk(g, "busy", 128'(busy), 128'(m_job));
            chk(g, "st_done", 128'(st_done), 128'(e_done_st));
            chk(g, "ks_done", 128'(ks_done), 128'(e_done_ks));
            chk(g, "st_out", st_out, m_st);
            chk(g, "ks_out", 128'(ks_out), 128'(m_ks));
            chk(g, "sb_in", 128'(sb_in), 128'(e_sb));
            if (!rst && (e_rdy_st || e_rdy_ks)) begin
                m_job    = 1;
                m_c0     = cyc;
                m_own_ks = e_rdy_ks;
                m_ptr_ks = !e_rdy_ks;
                m_data   = e_rdy_ks ? {ks_in, 96'h0} : st_in;
                m_n      = e_rdy_ks ? 4 : 16;
                exp_q.push_back(sub_all(m_data));
            end
        end

        task automatic do_reset();
            @(posedge clk); #1;
            rst = 1'b1; st_req_valid = 1'b0; ks_req_valid = 1'b0;
            @(negedge clk); #1;
            chk(g, "reset st_out", st_out, 128'h0);
            chk(g, "reset ks_out", 128'(ks_out), 128'h0);
            chk(g, "reset busy", 128'(busy), 128'h0);
            chk(g, "reset sb_in", 128'(sb_in), 128'h0);
            @(posedge clk); #1;
            rst = 1'b0;
        endtask

        task automatic do_job(input bit is_ks, input logic [127:0] d, output int lat);
            int acc;
            acc = -1; lat = -1;
            @(posedge clk); #1;
            if (is_ks) begin ks_in = d[31:0]; ks_req_valid = 1'b1; end
            else begin st_in = d; st_req_valid = 1'b1; end
            for (int t = 0; t < 100 && lat < 0; t++) begin
                @(negedge clk); #1;
                if (acc < 0 && (is_ks ? ks_req_ready : st_req_ready)) acc = cyc;
                else if (acc >= 0 && (is_ks ? ks_done : st_done)) lat = cyc - acc;
                if (acc == cyc) begin
                    @(posedge clk); #1;
                    st_req_valid = 1'b0; ks_req_valid = 1'b0;
                    st_in = rand128(); ks_in = $urandom;
                end
            end
            chk(g, "job completes", 128'(lat >= 0), 128'h1);
        endtask

        task automatic wait_idle();
            for (int t = 0; t < 100 && (busy || st_req_valid || ks_req_valid); t++) begin
                @(negedge clk); #1;
            end
            chk(g, "returns idle", 128'(busy), 128'h0);
        endtask

        initial begin : drive
            int         lat, ng, ks_left, pulses;
            logic [2:0] ord;
            bit         sa, ka;
            rst = 1'b1; st_req_valid = 1'b0; ks_req_valid = 1'b0;
            st_in = '0; ks_in = '0;
            do_reset();

            do_job(1'b1, {96'h0, 32'hcf4f3c09}, lat);
            chk(g, "key latency", 128'(lat), (LAT == 3) ? 128'd8 : 128'd6);
            chk(g, "key result", 128'(ks_out), 128'h8a84eb01);
            chk(g, "st_out untouched", st_out, 128'h0);

            do_job(1'b0, 128'h00112233445566778899aabbccddeeff, lat);
            chk(g, "state latency", 128'(lat), (LAT == 3) ? 128'd20 : 128'd18);
            chk(g, "state result", st_out, 128'h638293c31bfc33f5c4eeacea4bc12816);
            chk(g, "ks_out kept", 128'(ks_out), 128'h8a84eb01);

            for (int i = 0; i < 5; i++) begin
                do_job(1'b1, {96'h0, singles[i], 24'h0}, lat);
                chk(g, "single byte", 128'(ks_out), 128'({singles_sb[i], 24'h636363}));
            end

            // Abandon a state job part-way with reset.
            @(posedge clk); #1;
            st_in = rand128(); st_req_valid = 1'b1;
            @(negedge clk); #1;
            chk(g, "abort job ready", 128'(st_req_ready), 128'h1);
            @(posedge clk); #1;
            st_req_valid = 1'b0;
            repeat (7) @(posedge clk);
            #1 rst = 1'b1;
            #1;
            chk(g, "async st_out", st_out, 128'h0);
            chk(g, "async ks_out", 128'(ks_out), 128'h0);
            chk(g, "async busy", 128'(busy), 128'h0);
            chk(g, "async sb_in", 128'(sb_in), 128'h0);
            @(posedge clk); #1;
            rst = 1'b0;
            pulses = 0;
            repeat (30) begin
                @(negedge clk); #1;
                pulses += int'(st_done);
            end
            chk(g, "no done after reset", 128'(pulses), 128'h0);
            do_job(1'b0, 128'h00112233445566778899aabbccddeeff, lat);
            chk(g, "post-reset latency", 128'(lat), (LAT == 3) ? 128'd20 : 128'd18);
            chk(g, "post-reset result", st_out, 128'h638293c31bfc33f5c4eeacea4bc12816);

            // Collisions from reset: key requests two jobs back to back, state one.
            do_reset();
            @(posedge clk); #1;
            st_in = rand128(); ks_in = $urandom;
            st_req_valid = 1'b1; ks_req_valid = 1'b1;
            ks_left = 2; ng = 0; ord = '0;
            for (int t = 0; t < 300 && ng < 3; t++) begin
                @(negedge clk); #1;
                sa = st_req_valid && st_req_ready;
                ka = ks_req_valid && ks_req_ready;
                @(posedge clk); #1;
                if (ka) begin
                    ord = {ord[1:0], 1'b1}; ng++; ks_left--; ks_in = $urandom;
                    if (ks_left == 0) ks_req_valid = 1'b0;
                end
                if (sa) begin
                    ord = {ord[1:0], 1'b0}; ng++; st_req_valid = 1'b0; st_in = rand128();
                end
            end
            chk(g, "collision grants", 128'(ng), 128'd3);
            chk(g, "collision order", 128'(ord), RR ? 128'h5 : 128'h6);
            wait_idle();

            for (int t = 0; t < 400; t++) begin
                @(negedge clk); #1;
                sa = st_req_valid && st_req_ready;
                ka = ks_req_valid && ks_req_ready;
                @(posedge clk); #1;
                if (sa) begin
                    st_in = rand128(); st_req_valid = ($urandom_range(0, 2) == 0);
                end else if (!st_req_valid && $urandom_range(0, 3) == 0) begin
                    st_in = rand128(); st_req_valid = 1'b1;
                end
                if (ka) begin
                    ks_in = $urandom; ks_req_valid = ($urandom_range(0, 2) == 0);
                end else if (!ks_req_valid && $urandom_range(0, 3) == 0) begin
                    ks_in = $urandom; ks_req_valid = 1'b1;
                end
            end
            @(negedge clk); #1;
            sa = st_req_valid && st_req_ready;
            ka = ks_req_valid && ks_req_ready;
            @(posedge clk); #1;
            if (sa || !ka) st_req_valid = 1'b0;
            if (ka || !sa) ks_req_valid = 1'b0;
            for (int t = 0; t < 40 && (st_req_valid || ks_req_valid); t++) begin
                @(negedge clk); #1;
                sa = st_req_valid && st_req_ready;
                ka = ks_req_valid && ks_req_ready;
                @(posedge clk); #1;
                if (sa) st_req_valid = 1'b0;
                if (ka) ks_req_valid = 1'b0;
            end
            wait_idle();
            repeat (3) @(negedge clk);
            fin = 1'b1;
        end
    end

    initial begin : main
        bit all_fin;
        all_fin = 1'b0;
        for (int t = 0; t < 20000 && !all_fin; t++) begin
            @(negedge clk); #2;
            all_fin = cfg[0].fin && cfg[1].fin && cfg[2].fin;
        end
        chk(-1, "all configs finished", 128'(all_fin), 128'h1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
